// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction/PC, one-cycle latency, and
// decodes register fields plus immediate-format select; StallD holds, FlushD inserts a bubble.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter logic [31:0] RESET_PC  = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   input  logic [31:0] PCF,
   input  logic [31:0] PCPlus4F,
   input  logic        ValidF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic [4:0]  Rs1D,
   output logic [4:0]  Rs2D,
   output logic [4:0]  RdD,
   output logic [24:0] ImmD,
   output logic [2:0]  ImmSrcD,
   output logic        IllegalD
);

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Flush outranks stall so a squashed instruction can't linger in a held stage.
   always_ff @(posedge clk) begin
      if (rst || FlushD) begin
         InstrD   <= NOP_INSTR;
         PCD      <= RESET_PC;
         PCPlus4D <= RESET_PC + 32'd4;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= PCPlus4F;
         ValidD   <= ValidF;
      end
   end

   assign Rs1D = InstrD[19:15];
   assign Rs2D = InstrD[24:20];
   assign RdD  = InstrD[11:7];
   assign ImmD = InstrD[31:7];

   logic [6:0] opcode;
   logic       known_op;
   assign opcode = InstrD[6:0];

   // Unused selects (R-type, fence, unknown) stay at I so the extender never sees 101-111.
   always_comb begin
      ImmSrcD  = IMM_I;
      known_op = 1'b1;
      case (opcode)
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: ImmSrcD = IMM_I;
         7'b0100011:                                     ImmSrcD = IMM_S;
         7'b1100011:                                     ImmSrcD = IMM_B;
         7'b1101111:                                     ImmSrcD = IMM_J;
         7'b0110111, 7'b0010111:                         ImmSrcD = IMM_U;
         7'b0110011, 7'b0001111:                         ImmSrcD = IMM_I;
         default:                                        known_op = 1'b0;
      endcase
   end

   assign IllegalD = ValidD && !known_op;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed scoreboard bench for if_id_reg: expected D-stage state is queued per step
// and compared field by field one cycle later.
module tb_if_id_reg;

   logic        clk = 1'b0;
   logic        rst, StallD, FlushD, ValidF;
   logic [31:0] InstrF, PCF, PCPlus4F;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, IllegalD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [24:0] ImmD;
   logic [2:0]  ImmSrcD;

   if_id_reg dut (
      .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmD(ImmD),
      .ImmSrcD(ImmSrcD), .IllegalD(IllegalD)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic        valid;
      logic [2:0]  immsrc;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // Reference register state, updated by the bench's own priority rules.
   logic [31:0] m_instr, m_pc, m_pcp4;
   logic        m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic r, input logic fl, input logic st,
                       input logic [31:0] instr, input logic [31:0] pc, input logic v,
                       input logic [2:0] e_immsrc, input logic e_illegal);
      exp_t e;
      rst = r; FlushD = fl; StallD = st;
      InstrF = instr; PCF = pc; PCPlus4F = pc + 32'd4; ValidF = v;
      if (r || fl) begin
         m_instr = 32'h00000013; m_pc = 32'h0; m_pcp4 = 32'h4; m_valid = 1'b0;
      end else if (!st) begin
         m_instr = instr; m_pc = pc; m_pcp4 = pc + 32'd4; m_valid = v;
      end
      e.instr = m_instr; e.pc = m_pc; e.pcp4 = m_pcp4; e.valid = m_valid;
      e.immsrc = e_immsrc; e.illegal = e_illegal;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("InstrD",   InstrD,             e.instr);
      check("PCD",      PCD,                e.pc);
      check("PCPlus4D", PCPlus4D,           e.pcp4);
      check("ValidD",   {31'b0, ValidD},    {31'b0, e.valid});
      check("Rs1D",     {27'b0, Rs1D},      {27'b0, e.instr[19:15]});
      check("Rs2D",     {27'b0, Rs2D},      {27'b0, e.instr[24:20]});
      check("RdD",      {27'b0, RdD},       {27'b0, e.instr[11:7]});
      check("ImmD",     {7'b0, ImmD},       {7'b0, e.instr[31:7]});
      check("ImmSrcD",  {29'b0, ImmSrcD},   {29'b0, e.immsrc});
      check("IllegalD", {31'b0, IllegalD},  {31'b0, e.illegal});
   endtask

   initial begin
      m_instr = 32'h0; m_pc = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      // reset held two cycles with garbage on the fetch side
      step(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1, 3'b000, 0);
      step(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1, 3'b000, 0);
      // load and decode: sw x5,-4(x2)
      step(0, 0, 0, 32'hFE512E23, 32'h100, 1, 3'b001, 0);
      // format sweep
      step(0, 0, 0, 32'h008000EF, 32'h104, 1, 3'b011, 0);
      step(0, 0, 0, 32'h00208463, 32'h108, 1, 3'b010, 0);
      step(0, 0, 0, 32'h12345037, 32'h10C, 1, 3'b100, 0);
      step(0, 0, 0, 32'h00A00093, 32'h110, 1, 3'b000, 0);
      step(0, 0, 0, 32'h00B50533, 32'h114, 1, 3'b000, 0);
      step(0, 0, 0, 32'h0000000F, 32'h118, 1, 3'b000, 0);
      step(0, 0, 0, 32'h00002017, 32'h11C, 1, 3'b100, 0);
      // stall: hold addi for three cycles while fetch changes
      step(0, 0, 0, 32'h00A00093, 32'h200, 1, 3'b000, 0);
      step(0, 0, 1, 32'h008000EF, 32'h204, 1, 3'b000, 0);
      step(0, 0, 1, 32'hFE512E23, 32'h208, 1, 3'b000, 0);
      step(0, 0, 1, 32'h0000007F, 32'h20C, 1, 3'b000, 0);
      step(0, 0, 0, 32'h00208463, 32'h210, 1, 3'b010, 0);
      // flush beats stall
      step(0, 0, 0, 32'hFE512E23, 32'h300, 1, 3'b001, 0);
      step(0, 1, 1, 32'h008000EF, 32'h304, 1, 3'b000, 0);
      // illegal opcode, valid and not valid
      step(0, 0, 0, 32'h0000007F, 32'h400, 1, 3'b000, 1);
      step(0, 0, 0, 32'h0000007F, 32'h404, 0, 3'b000, 0);
      // mid-stream reset wins over stall, then loads normally
      step(0, 0, 0, 32'h12345037, 32'h500, 1, 3'b100, 0);
      step(1, 0, 1, 32'h008000EF, 32'h504, 1, 3'b000, 0);
      step(0, 0, 0, 32'h008000EF, 32'h508, 1, 3'b011, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
